// File: rtl/apu_dispatch_if.sv
// apu_dispatch_if: bundles the four handshakes of the APU dispatcher.
//   core issue : Req_SI/Ready_SO + OpA_DI, OpB_DI, Op_SI, RM_SI, Rd_DI
//   APU request: Valid_SO/ApuReady_SI + ArgA_DO, ArgB_DO, OpCmd_SO, RM_SO, Tag_DO
//   APU result : ResValid_SI + Result_DI, ResFlags_DI, ResTag_DI (no back-pressure)
//   writeback  : WbValid_SO/WbReady_SI + WbData_DO, WbRd_DO, WbFlags_DO
//   StrayTag_SO: pulse for a result whose tag was not outstanding
// Modports: slave = the dispatcher, master = core/APU/regfile environment.
interface apu_dispatch_if #(
    parameter int C_TAG = 4
);
    logic             Req_SI;
    logic             Ready_SO;
    logic [31:0]      OpA_DI;
    logic [31:0]      OpB_DI;
    logic [3:0]       Op_SI;
    logic [2:0]       RM_SI;
    logic [4:0]       Rd_DI;

    logic             Valid_SO;
    logic             ApuReady_SI;
    logic [31:0]      ArgA_DO;
    logic [31:0]      ArgB_DO;
    logic [3:0]       OpCmd_SO;
    logic [2:0]       RM_SO;
    logic [C_TAG-1:0] Tag_DO;

    logic             ResValid_SI;
    logic [31:0]      Result_DI;
    logic [8:0]       ResFlags_DI;
    logic [C_TAG-1:0] ResTag_DI;

    logic             WbValid_SO;
    logic             WbReady_SI;
    logic [31:0]      WbData_DO;
    logic [4:0]       WbRd_DO;
    logic [4:0]       WbFlags_DO;

    logic             StrayTag_SO;

    modport slave (
        input  Req_SI, OpA_DI, OpB_DI, Op_SI, RM_SI, Rd_DI,
        output Ready_SO,
        output Valid_SO, ArgA_DO, ArgB_DO, OpCmd_SO, RM_SO, Tag_DO,
        input  ApuReady_SI,
        input  ResValid_SI, Result_DI, ResFlags_DI, ResTag_DI,
        output WbValid_SO, WbData_DO, WbRd_DO, WbFlags_DO,
        input  WbReady_SI,
        output StrayTag_SO
    );

    modport master (
        output Req_SI, OpA_DI, OpB_DI, Op_SI, RM_SI, Rd_DI,
        input  Ready_SO,
        input  Valid_SO, ArgA_DO, ArgB_DO, OpCmd_SO, RM_SO, Tag_DO,
        output ApuReady_SI,
        output ResValid_SI, Result_DI, ResFlags_DI, ResTag_DI,
        input  WbValid_SO, WbData_DO, WbRd_DO, WbFlags_DO,
        output WbReady_SI,
        input  StrayTag_SO
    );
endinterface

// File: rtl/apu_dispatch.sv
// apu_dispatch: issues core operations to an APU with tag allocation,
// collects out-of-order results into a result FIFO and writes them back.
// Ports:
//   Clk_CI  - clock, rising edge
//   Rst_RBI - asynchronous active-low reset
//   bus     - apu_dispatch_if.slave (issue, APU request, result, writeback)
// Parameters: MAX_OUT (2..8) ops in flight, C_TAG tag width (2^C_TAG >= MAX_OUT).
// Optional: define APU_DISPATCH_BYPASS_EN to let a result hitting an empty
// FIFO with WbReady_SI high write back in the same cycle.
module apu_dispatch #(
    parameter int MAX_OUT = 4,
    parameter int C_TAG   = 4
) (
    input  logic          Clk_CI,
    input  logic          Rst_RBI,
    apu_dispatch_if.slave bus
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } wb_t;

    // downstream request register
    logic             valid_q;
    logic [31:0]      arga_q, argb_q;
    logic [3:0]       op_q;
    logic [2:0]       rm_q;
    logic [C_TAG-1:0] tag_q;

    // tag bookkeeping
    logic [MAX_OUT-1:0] free_q, free_d;
    logic [4:0]         rd_tab [MAX_OUT];
    logic [CW-1:0]      out_cnt_q;

    // result FIFO
    wb_t           fifo_mem [MAX_OUT];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] fifo_cnt_q;

    logic stray_q;

    logic          credit_ok, ready, issue;
    logic [PW-1:0] alloc_idx, res_idx;
    logic          res_in_range, hit, bypass, push, pop, fifo_empty, wb_valid;
    wb_t           res_ent, wb_ent;
    logic          unused_flags;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts both in-flight tags and parked results, so a result can
    // always find a FIFO slot.
    assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(MAX_OUT);
    assign ready     = credit_ok && (!valid_q || bus.ApuReady_SI);
    assign issue     = bus.Req_SI && ready;

    // Lowest-index free tag; credit_ok guarantees one exists when issuing.
    always_comb begin
        alloc_idx = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--)
            if (free_q[i]) alloc_idx = PW'(i);
    end

    assign res_in_range = {1'b0, bus.ResTag_DI} < (C_TAG + 1)'(MAX_OUT);
    assign res_idx      = bus.ResTag_DI[PW-1:0];
    assign hit          = bus.ResValid_SI && res_in_range && !free_q[res_idx];

    // {NV,DZ,OF,UF,NX}; divide-by-zero is never reported by this APU
    assign res_ent = {bus.Result_DI, rd_tab[res_idx],
                      bus.ResFlags_DI[6], 1'b0, bus.ResFlags_DI[0],
                      bus.ResFlags_DI[1], bus.ResFlags_DI[5]};
    assign unused_flags = ^{bus.ResFlags_DI[8:7], bus.ResFlags_DI[4:2]};

    assign fifo_empty = (fifo_cnt_q == '0);

`ifdef APU_DISPATCH_BYPASS_EN
    assign bypass = hit && fifo_empty && bus.WbReady_SI;
`else
    assign bypass = 1'b0;
`endif

    assign push     = hit && !bypass;
    assign pop      = !fifo_empty && bus.WbReady_SI;
    assign wb_valid = !fifo_empty || bypass;
    assign wb_ent   = fifo_empty ? res_ent : fifo_mem[rptr_q];

    always_comb begin
        free_d = free_q;
        if (hit)   free_d[res_idx]   = 1'b1;
        if (issue) free_d[alloc_idx] = 1'b0;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            valid_q    <= 1'b0;
            arga_q     <= '0;
            argb_q     <= '0;
            op_q       <= '0;
            rm_q       <= '0;
            tag_q      <= '0;
            free_q     <= '1;
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            stray_q    <= 1'b0;
        end else begin
            if (issue) begin
                valid_q <= 1'b1;
                arga_q  <= bus.OpA_DI;
                argb_q  <= bus.OpB_DI;
                op_q    <= bus.Op_SI;
                rm_q    <= bus.RM_SI;
                tag_q   <= C_TAG'(alloc_idx);
            end else if (bus.ApuReady_SI) begin
                valid_q <= 1'b0;
            end
            free_q    <= free_d;
            out_cnt_q <= out_cnt_q + CW'(issue) - CW'(hit);
            if (push != pop)
                fifo_cnt_q <= push ? fifo_cnt_q + CW'(1) : fifo_cnt_q - CW'(1);
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            stray_q <= bus.ResValid_SI && !hit;
        end
    end

    // Storage arrays need no reset: validity lives in free_q / fifo_cnt_q.
    always_ff @(posedge Clk_CI) begin
        if (issue) rd_tab[alloc_idx] <= bus.Rd_DI;
        if (push)  fifo_mem[wptr_q]  <= res_ent;
    end

    assign bus.Ready_SO    = ready;
    assign bus.Valid_SO    = valid_q;
    assign bus.ArgA_DO     = arga_q;
    assign bus.ArgB_DO     = argb_q;
    assign bus.OpCmd_SO    = op_q;
    assign bus.RM_SO       = rm_q;
    assign bus.Tag_DO      = tag_q;
    assign bus.WbValid_SO  = wb_valid;
    assign bus.WbData_DO   = wb_valid ? wb_ent.data  : '0;
    assign bus.WbRd_DO     = wb_valid ? wb_ent.rd    : '0;
    assign bus.WbFlags_DO  = wb_valid ? wb_ent.flags : '0;
    assign bus.StrayTag_SO = stray_q;
endmodule

// File: doc/apu_dispatch.md
APU_DISPATCH -- requirements
Module: apu_dispatch

Interface
REQ-001 Parameter MAX_OUT, default 4, maximum operations in flight (issued but not written back); legal values 2..8.
REQ-002 Parameter C_TAG, default 4, tag width; SHALL satisfy 2^C_TAG >= MAX_OUT.
REQ-003 Clk_CI  in  1  clock, rising edge.
REQ-004 Rst_RBI  in  1  reset, asynchronous, active-low.
REQ-005 Req_SI / Ready_SO  in/out  1/1  core issue handshake; transfer when both are high.
REQ-006 OpA_DI, OpB_DI  in  32  operands; Op_SI  in  4  command; RM_SI  in  3  rounding mode; Rd_DI  in  5  destination register.
REQ-007 Valid_SO / ApuReady_SI  out/in  1/1  downstream request handshake to the APU.
REQ-008 ArgA_DO, ArgB_DO  out  32; OpCmd_SO  out  4; RM_SO  out  3; Tag_DO  out  C_TAG; downstream request payload.
REQ-009 ResValid_SI  in  1  upstream result strobe, no back-pressure; Result_DI  in  32; ResFlags_DI  in  9; ResTag_DI  in  C_TAG.
REQ-010 WbValid_SO / WbReady_SI  out/in  1/1  writeback handshake; WbData_DO  out  32; WbRd_DO  out  5; WbFlags_DO  out  5 as {NV,DZ,OF,UF,NX}.
REQ-011 StrayTag_SO  out  1  one-cycle pulse on a result whose tag is not outstanding.

Function
REQ-012 Issue: a one-entry output register SHALL hold the downstream payload; Valid_SO and payload SHALL stay stable until ApuReady_SI is high.
REQ-013 Ready_SO = credit_ok AND (NOT Valid_SO OR ApuReady_SI), where credit_ok = (outstanding + fifo_count) < MAX_OUT.
REQ-014 Latency: a core transfer in cycle N SHALL give Valid_SO high in cycle N+1 with that payload.
REQ-015 Tag allocation: the lowest-index free tag SHALL be chosen from the registered free vector; the tag and Rd_DI SHALL be recorded in the tag table at core transfer.
REQ-016 A tag freed in cycle N SHALL be allocatable no earlier than cycle N+1.
REQ-017 Result: on ResValid_SI with an outstanding ResTag_DI, the entry {Result_DI, Rd from table, mapped flags} SHALL be pushed into a result FIFO of depth MAX_OUT, and the tag SHALL be freed in the same cycle.
REQ-018 Flag mapping: NV=ResFlags_DI[6], DZ=0, OF=ResFlags_DI[0], UF=ResFlags_DI[1], NX=ResFlags_DI[5].
REQ-019 Stray result (tag not outstanding): SHALL be discarded, StrayTag_SO pulses for one cycle, and no state changes.
REQ-020 Writeback: WbValid_SO SHALL equal FIFO not-empty; payload is the FIFO head; pop when WbValid_SO and WbReady_SI are both high.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo MAX_OUT.
REQ-022 Simultaneous issue and result-push SHALL update outstanding by +1 and -1 (net 0); the credit check SHALL use registered counts.
REQ-023 The credit rule SHALL make FIFO overflow unreachable; an in-order or out-of-order tag return SHALL both be accepted.

Reset
REQ-024 On Rst_RBI low, at any time including mid-operation: Valid_SO=0, WbValid_SO=0, StrayTag_SO=0, all tags free, outstanding=0, fifo empty, payload outputs 0.
REQ-025 Ready_SO SHALL be 1 in the first cycle after reset release.
REQ-026 In-flight operations SHALL be dropped on reset; results that arrive after reset SHALL be treated as stray.

Configuration
REQ-027 Macro APU_DISPATCH_BYPASS_EN: when defined, a non-stray result arriving while the FIFO is empty and WbReady_SI is high SHALL drive writeback in the same cycle, without a push.
REQ-028 Without APU_DISPATCH_BYPASS_EN, writeback SHALL occur no earlier than the cycle after ResValid_SI (minimum 1-cycle latency).

Verification
REQ-029 Single op: OpA=0x3F800000, OpB=0x40000000, Rd=5, ApuReady=1 -> Valid_SO next cycle with Tag=0; result tag 0, flags 0x020 -> WbRd=5, WbFlags=5'b00001.
REQ-030 Back-pressure: ApuReady=0 for 3 cycles -> Valid_SO and payload stable, Ready_SO=0 with one entry pending, one transfer when ApuReady rises.
REQ-031 Credit limit: issue 4 ops with no results -> Ready_SO=0 after the 4th; one result with WbReady=0 -> Ready_SO still 0; pop -> Ready_SO=1.
REQ-032 Out-of-order return: tags 0,1,2 issued, results in order 2,0,1 -> writebacks in order Rd(2),Rd(0),Rd(1); freed tags 0 and 1 reused lowest-first.
REQ-033 Stray: result with tag 3 when none outstanding -> StrayTag_SO=1 for one cycle, no writeback; reset asserted mid-flight -> all outputs 0 and Ready_SO=1 after release.
REQ-034 Bypass: with APU_DISPATCH_BYPASS_EN, empty FIFO and WbReady=1 -> WbValid_SO in the same cycle as ResValid_SI; without the macro -> WbValid_SO one cycle later.
